alu_mp_seq: RTL
===============

// Module: alu_mp_seq
// PURPOSE
//  Multi-precision sequencer for the 8-bit ALU_ABC slice (opcodes from package definitionsABC).
//  Accepts one 16-bit (NSLICE*8) ADD/SUB/SHL request per valid/ready handshake and drives the ALU one byte per step.
//  Chains carry through ALU SC_IN/SC_OUT and returns the result with carry and zero flags.
//  Sits between the decode/issue stage and the single shared ALU; owns all ALU inputs while busy.
// PARAMETERS
//  NSLICE  2  number of 8-bit slices per operand (result width = 8*NSLICE), >=1
//  OPW     4  ALU opcode width
// PORTS
//  CLK         in   1         clock, all state on rising edge
//  RESET_N     in   1         asynchronous, active-low reset
//  REQ_VALID   in   1         request present
//  REQ_READY   out  1         sequencer can accept (high only in IDLE)
//  REQ_OP      in   2         00 ADD, 01 SUB, 10 SHL, 11 reserved
//  REQ_A       in   8*NSLICE  operand A (SHL: value to shift)
//  REQ_B       in   8*NSLICE  operand B (ignored for SHL)
//  RES_VALID   out  1         result held until consumed
//  RES_READY   in   1         consumer takes result
//  RES_DATA    out  8*NSLICE  result
//  RES_CARRY   out  1         ADD: carry out; SUB: 1 = no borrow (A>=B unsigned); SHL: bit shifted out
//  RES_ZERO    out  1         RES_DATA == 0
//  ALU_OP      out  OPW       to ALU OP
//  ALU_A       out  8         to ALU INPUTA
//  ALU_B       out  8         to ALU INPUTB
//  ALU_SC_IN   out  1         to ALU SC_IN
//  ALU_OUT     in   8         from ALU OUT (combinational, same cycle)
//  ALU_SC_OUT  in   1         from ALU SC_OUT
// BEHAVIOUR
//  Reset: state IDLE, slice idx 0, REQ_READY=1 after reset release, RES_VALID=0, RES_DATA=0,
//   RES_CARRY=0, RES_ZERO=0; operand/carry registers 0. Reset mid-operation discards the op immediately.
//  Idle ALU drive (IDLE/DONE): ALU_OP=kADDL, ALU_A=ALU_B=0, ALU_SC_IN=0.
//  Accept: edge with REQ_VALID&&REQ_READY latches REQ_OP/A/B; later input changes are ignored.
//  States: IDLE, NOTB, ADD, DONE. Slice idx k counts 0..NSLICE-1, low slice first.
//  ADD: each ADD cycle drives kADDL, A=A[k], B=B[k], SC_IN=(k==0)?0:carry_reg;
//   at the edge ALU_OUT->res[k], ALU_SC_OUT->carry_reg. k==NSLICE-1 -> DONE, else k++.
//  SHL: identical to ADD with ALU_B=A[k] (A+A); carry out = old MSB.
//  SUB: A + ~B + 1, two cycles per slice: NOTB drives kNOT, B=B[k], latches ALU_OUT into nb reg -> ADD;
//   ADD drives kADDL, A[k], nb, SC_IN=(k==0)?1:carry_reg, then NOTB for k+1 or DONE after last slice.
//  Reserved op 11: IDLE -> DONE directly, RES_DATA=0, RES_CARRY=0, RES_ZERO=1; ALU not driven.
//  Latency (accept edge = 0): RES_VALID rises at edge NSLICE+1 (ADD/SHL), 2*NSLICE+1 (SUB), 1 (reserved).
//  DONE: RES_VALID=1, RES_DATA/CARRY/ZERO stable; on RES_READY edge -> IDLE, RES_VALID=0 next cycle.
//  RES_DATA/flags keep last value after consumption until the next result lands; REQ_READY=0 in NOTB/ADD/DONE.
//  Overflow/wrap: results are modulo 2^(8*NSLICE); only carry flag reports excess.
// TESTING (NSLICE=2)
//  ADD A=0x12FF B=0x0001 -> RES_DATA=0x1300, CARRY=0, ZERO=0, RES_VALID at edge 3 after accept.
//  ADD A=0xFFFF B=0x0001 -> RES_DATA=0x0000, CARRY=1, ZERO=1; ALU_SC_IN=1 seen in slice-1 cycle.
//  SUB 0x1000-0x0001 -> 0x0FFF CARRY=1; SUB 0x0001-0x0002 -> 0xFFFF CARRY=0; RES_VALID at edge 5.
//  SHL A=0x8081 -> RES_DATA=0x0102, CARRY=1; SHL A=0x4000 -> 0x8000, CARRY=0.
//  Hold RES_READY=0 for 5 cycles with REQ_VALID=1 -> RES_* stable, REQ_READY=0, no new accept; then take.
//  RESET_N low during SUB slice-1 NOTB -> RES_VALID/RES_DATA 0 at once, IDLE; op 11 -> DONE after 1 edge, ZERO=1.

Source files
------------

// File: rtl/alu_mp_seq.sv
// Multi-precision ADD/SUB/SHL sequencer driving one shared 8-bit ALU slice per cycle.
// Carries chain low slice first through the ALU SC_IN/SC_OUT pair.
package definitionsABC;
  localparam logic [3:0] kADDL = 4'h2;
  localparam logic [3:0] kNOT  = 4'h9;
endpackage

module alu_mp_seq
  import definitionsABC::*;
#(
  parameter int NSLICE = 2,
  parameter int OPW    = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic [1:0]          REQ_OP,
  input  logic [8*NSLICE-1:0] REQ_A,
  input  logic [8*NSLICE-1:0] REQ_B,
  output logic                RES_VALID,
  input  logic                RES_READY,
  output logic [8*NSLICE-1:0] RES_DATA,
  output logic                RES_CARRY,
  output logic                RES_ZERO,
  output logic [OPW-1:0]      ALU_OP,
  output logic [7:0]          ALU_A,
  output logic [7:0]          ALU_B,
  output logic                ALU_SC_IN,
  input  logic [7:0]          ALU_OUT,
  input  logic                ALU_SC_OUT
);
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, NOTB, ADD, DONE} state_t;

  state_t                  state, state_nx;
  logic [1:0]              op_q;
  logic [NSLICE-1:0][7:0]  a_q, b_q, wrk_q;
  logic [7:0]              nb_q;
  logic                    carry_q;
  logic [IW-1:0]           idx;
  logic                    res_valid_q, res_carry_q, res_zero_q;
  logic [8*NSLICE-1:0]     res_q;

  logic is_sub, is_shl, last;
  assign is_sub = (op_q == 2'b01);
  assign is_shl = (op_q == 2'b10);
  assign last   = (idx == LAST);

  assign REQ_READY = (state == IDLE);
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_q;
  assign RES_CARRY = res_carry_q;
  assign RES_ZERO  = res_zero_q;

  always_comb begin
    state_nx  = state;
    ALU_OP    = OPW'(kADDL);
    ALU_A     = 8'h00;
    ALU_B     = 8'h00;
    ALU_SC_IN = 1'b0;
    case (state)
      IDLE: if (REQ_VALID) begin
        case (REQ_OP)
          2'b00, 2'b10: state_nx = ADD;
          2'b01:        state_nx = NOTB;
          default:      state_nx = DONE;
        endcase
      end
      NOTB: begin
        ALU_OP   = OPW'(kNOT);
        ALU_B    = b_q[idx];
        state_nx = ADD;
      end
      ADD: begin
        ALU_A = a_q[idx];
        ALU_B = is_sub ? nb_q : (is_shl ? a_q[idx] : b_q[idx]);
        // SUB is A + ~B + 1: the +1 enters as carry-in of the lowest slice
        ALU_SC_IN = (idx == '0) ? is_sub : carry_q;
        state_nx  = last ? DONE : (is_sub ? NOTB : ADD);
      end
      DONE: if (res_valid_q && RES_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      wrk_q       <= '0;
      nb_q        <= 8'h00;
      carry_q     <= 1'b0;
      idx         <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (REQ_VALID) begin
          op_q    <= REQ_OP;
          a_q     <= REQ_A;
          b_q     <= REQ_B;
          idx     <= '0;
          carry_q <= 1'b0;
          wrk_q   <= '0;
        end
        NOTB: nb_q <= ALU_OUT;
        ADD: begin
          wrk_q[idx] <= ALU_OUT;
          carry_q    <= ALU_SC_OUT;
          if (!last) idx <= idx + 1'b1;
        end
        DONE: begin
          // result lands one edge after entering DONE; outputs hold until the next landing
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
            res_q       <= wrk_q;
            res_carry_q <= carry_q;
            res_zero_q  <= (wrk_q == '0);
          end else if (RES_READY) begin
            res_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
